// File: rtl/mc_sw_alloc_pkg.sv
// Shared constants and mode codes for the multicast-capable switch allocator.
package mc_sw_alloc_pkg;

    localparam int unsigned NPORT     = 5;
    localparam int unsigned PW        = 3;
    localparam int unsigned LOCAL_IDX = 4;

    localparam int unsigned PORT_N     = 0;
    localparam int unsigned PORT_E     = 1;
    localparam int unsigned PORT_S     = 2;
    localparam int unsigned PORT_W     = 3;
    localparam int unsigned PORT_LOCAL = LOCAL_IDX;

    typedef enum logic [1:0] {
        MODE_UNICAST = 2'b00,
        MODE_MULTFWD = 2'b01,
        MODE_MULTABS = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    // Next index in round-robin order.
    function automatic logic [PW-1:0] port_inc(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        n = p + PW'(1);
        if (n >= PW'(NPORT)) begin
            n = '0;
        end
        return n;
    endfunction

endpackage

// File: rtl/mc_need_dec.sv
// Decodes one input's routed port and mode into the set of outputs it must own.
module mc_need_dec
    import mc_sw_alloc_pkg::*;
(
    input  logic [PW-1:0]    port_i,
    input  logic [1:0]       mode_i,
    output logic [NPORT-1:0] need_c_o,
    output logic             valid_c_o
);

    always_comb begin
        need_c_o  = '0;
        valid_c_o = (port_i < PW'(NPORT));
        if (valid_c_o) begin
            need_c_o = NPORT'(1) << port_i;
            // Absorbing multicast also ejects a copy locally.
            if (mode_i == MODE_MULTABS) begin
                need_c_o[LOCAL_IDX] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mc_sw_alloc.sv
// Round-robin wormhole switch allocator with all-or-nothing multicast-absorb grants.
module mc_sw_alloc
    import mc_sw_alloc_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_,
    input  logic [NPORT-1:0]         req_i,
    input  logic [NPORT*PW-1:0]      port_i,
    input  logic [NPORT*2-1:0]       mode_i,
    input  logic [NPORT-1:0]         tail_i,
    output logic [NPORT-1:0]         grant_o,
    output logic [NPORT*NPORT-1:0]   sel_o,
    output logic [NPORT-1:0]         busy_o,
    output logic                     err_o
);

    logic [NPORT-1:0]       need_c [NPORT];
    logic [NPORT-1:0]       valid_c;

    logic [NPORT-1:0]       grant_q, grant_d;
    logic [NPORT*NPORT-1:0] sel_q, sel_d;
    logic [NPORT-1:0]       busy_q, busy_d;
    logic                   err_q, err_d;
    logic [PW-1:0]          rr_q, rr_d;

    logic [NPORT-1:0]       gnt_new;
    logic [NPORT-1:0]       claim;
    logic [NPORT-1:0]       rel;

    for (genvar g = 0; g < NPORT; g++) begin : g_dec
        mc_need_dec u_dec (
            .port_i    (port_i[g*PW +: PW]),
            .mode_i    (mode_i[g*2 +: 2]),
            .need_c_o  (need_c[g]),
            .valid_c_o (valid_c[g])
        );
    end

    // Greedy rotating-priority scan; outputs freed by a tail this cycle stay busy until the edge.
    always_comb begin
        logic       found;
        logic [PW-1:0] idx;
        gnt_new = '0;
        claim   = '0;
        err_d   = 1'b0;
        rr_d    = rr_q;
        found   = 1'b0;
        idx     = rr_q;
        for (int k = 0; k < NPORT; k++) begin
            if (req_i[idx] && !grant_q[idx]) begin
                if (!valid_c[idx]) begin
                    err_d = 1'b1;
                end else if ((need_c[idx] & (busy_q | claim)) == '0) begin
                    gnt_new[idx] = 1'b1;
                    claim        = claim | need_c[idx];
                    if (!found) begin
                        found = 1'b1;
                        rr_d  = port_inc(idx);
                    end
                end
            end
            idx = port_inc(idx);
        end
    end

    // Lock bookkeeping: drop slices owned by releasing inputs, then install new owners.
    always_comb begin
        rel     = tail_i & grant_q;
        grant_d = (grant_q & ~rel) | gnt_new;
        sel_d   = sel_q;
        busy_d  = '0;
        for (int o = 0; o < NPORT; o++) begin
            if ((sel_q[o*NPORT +: NPORT] & rel) != '0) begin
                sel_d[o*NPORT +: NPORT] = '0;
            end
            for (int i = 0; i < NPORT; i++) begin
                if (gnt_new[i] && need_c[i][o]) begin
                    sel_d[o*NPORT +: NPORT] = NPORT'(1) << i;
                end
            end
            busy_d[o] = |sel_d[o*NPORT +: NPORT];
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            grant_q <= '0;
            sel_q   <= '0;
            busy_q  <= '0;
            err_q   <= 1'b0;
            rr_q    <= '0;
        end else begin
            grant_q <= grant_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            rr_q    <= rr_d;
        end
    end

    assign grant_o = grant_q;
    assign sel_o   = sel_q;
    assign busy_o  = busy_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_mc_sw_alloc.sv
// Directed self-checking bench for the switch allocator.
module tb_mc_sw_alloc;
    import mc_sw_alloc_pkg::*;

    logic                   clk;
    logic                   rst_;
    logic [NPORT-1:0]       req;
    logic [NPORT*PW-1:0]    port;
    logic [NPORT*2-1:0]     mode;
    logic [NPORT-1:0]       tail;
    logic [NPORT-1:0]       grant_o;
    logic [NPORT*NPORT-1:0] sel_o;
    logic [NPORT-1:0]       busy_o;
    logic                   err_o;

    int errors = 0;
    int checks = 0;

    mc_sw_alloc dut (
        .clk     (clk),
        .rst_    (rst_),
        .req_i   (req),
        .port_i  (port),
        .mode_i  (mode),
        .tail_i  (tail),
        .grant_o (grant_o),
        .sel_o   (sel_o),
        .busy_o  (busy_o),
        .err_o   (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int i, input logic r, input int p, input int m);
        req[i]           = r;
        port[i*PW +: PW] = PW'(p);
        mode[i*2 +: 2]   = 2'(m);
    endtask

    task automatic pulse_tail(input int i);
        req[i]  = 1'b0;
        tail[i] = 1'b1;
        step();
        tail[i] = 1'b0;
    endtask

    initial begin
        rst_ = 1'b0;
        req  = '0;
        port = '0;
        mode = '0;
        tail = '0;
        #12;
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_sel",   32'(sel_o),   32'h0);
        chk("rst_busy",  32'(busy_o),  32'h0);
        chk("rst_err",   32'(err_o),   32'h0);
        rst_ = 1'b1;
        step();

        // Unicast contention, rr=0
        set_in(0, 1'b1, 1, 0);
        set_in(2, 1'b1, 1, 0);
        step();
        chk("t1_grant0", 32'(grant_o), 32'h01);
        chk("t1_sel0",   32'(sel_o),   32'h20);
        chk("t1_busy0",  32'(busy_o),  32'h02);
        req[0]  = 1'b0;
        tail[0] = 1'b1;
        step();
        tail[0] = 1'b0;
        chk("t1_rel_grant", 32'(grant_o), 32'h00);
        chk("t1_rel_busy",  32'(busy_o),  32'h00);
        step();
        chk("t1_grant2", 32'(grant_o), 32'h04);
        chk("t1_sel2",   32'(sel_o),   32'h80);
        pulse_tail(2);
        chk("t1_idle", 32'(grant_o), 32'h00);

        // Multicast absorb atomicity; rr=3 here
        set_in(3, 1'b1, 4, 0);
        step();
        chk("t2_g3", 32'(grant_o), 32'h08);
        chk("t2_b3", 32'(busy_o),  32'h10);
        req[3] = 1'b0;
        set_in(0, 1'b1, 2, 2);
        set_in(1, 1'b1, 2, 0);
        step();
        chk("t2_g31", 32'(grant_o), 32'h0A);
        chk("t2_b31", 32'(busy_o),  32'h14);
        chk("t2_s31", 32'(sel_o),   32'h800800);
        req[1]  = 1'b0;
        tail[3] = 1'b1;
        step();
        tail[3] = 1'b0;
        chk("t2_after3_g", 32'(grant_o), 32'h02);
        chk("t2_after3_b", 32'(busy_o),  32'h04);
        step();
        chk("t2_blocked_g", 32'(grant_o), 32'h02);
        tail[1] = 1'b1;
        step();
        tail[1] = 1'b0;
        chk("t2_after1_g", 32'(grant_o), 32'h00);
        step();
        chk("t2_g0", 32'(grant_o), 32'h01);
        chk("t2_b0", 32'(busy_o),  32'h14);
        chk("t2_s0", 32'(sel_o),   32'h100400);
        pulse_tail(0);

        // MULTABS targeting LOCAL only
        set_in(4, 1'b1, 4, 2);
        step();
        chk("t3_g", 32'(grant_o), 32'h10);
        chk("t3_b", 32'(busy_o),  32'h10);
        chk("t3_s", 32'(sel_o),   32'h1000000);
        pulse_tail(4);

        // Round-robin fairness; rr=0 after the LOCAL grant
        for (int i = 0; i < NPORT; i++) set_in(i, 1'b1, 0, 0);
        for (int n = 0; n < 6; n++) begin
            int exp_i;
            exp_i = n % NPORT;
            step();
            chk($sformatf("t4_g%0d", n), 32'(grant_o), 32'(1) << exp_i);
            chk($sformatf("t4_s%0d", n), 32'(sel_o),   32'(1) << exp_i);
            tail[exp_i] = 1'b1;
            step();
            tail[exp_i] = 1'b0;
            chk($sformatf("t4_rel%0d", n), 32'(busy_o), 32'h0);
        end
        req = '0;

        // Tail and re-request together on input 2
        set_in(2, 1'b1, 3, 0);
        step();
        chk("t6_g", 32'(grant_o), 32'h04);
        chk("t6_b", 32'(busy_o),  32'h08);
        tail[2] = 1'b1;
        step();
        tail[2] = 1'b0;
        chk("t6_rel_g", 32'(grant_o), 32'h00);
        chk("t6_rel_b", 32'(busy_o),  32'h00);
        step();
        chk("t6_regrant_g", 32'(grant_o), 32'h04);
        chk("t6_regrant_b", 32'(busy_o),  32'h08);
        pulse_tail(2);

        // Invalid port
        set_in(1, 1'b1, 6, 0);
        step();
        chk("t5_err",   32'(err_o),   32'h1);
        chk("t5_noget", 32'(grant_o), 32'h0);
        req[1] = 1'b0;
        step();
        chk("t5_err_clr", 32'(err_o), 32'h0);

        // Reset mid-packet with three outputs busy
        set_in(0, 1'b1, 0, 0);
        set_in(1, 1'b1, 1, 0);
        set_in(2, 1'b1, 2, 0);
        step();
        chk("t5_pre_g", 32'(grant_o), 32'h07);
        chk("t5_pre_s", 32'(sel_o),   32'h1041);
        #2;
        rst_ = 1'b0;
        #1;
        chk("t5_rst_g", 32'(grant_o), 32'h0);
        chk("t5_rst_b", 32'(busy_o),  32'h0);
        chk("t5_rst_s", 32'(sel_o),   32'h0);
        req  = '0;
        rst_ = 1'b1;
        set_in(0, 1'b1, 0, 0);
        set_in(4, 1'b1, 0, 0);
        step();
        chk("t5_rr0", 32'(grant_o), 32'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
